// File: rtl/cm0_fetch_pkg.sv
// +--------------------------------------------------------------------+
// | cm0_fetch_pkg : shared types and constants for the prefetch unit   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cm0_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   localparam int unsigned HW_BYTES   = 2;
   localparam int unsigned WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/cm0_fetch_fifo.sv
// +--------------------------------------------------------------------+
// | cm0_fetch_fifo : circular word buffer holding data + word address  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cm0_fetch_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WADDR_W = 30
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [31:0]                  push_data_i,
   input  logic [WADDR_W-1:0]           push_addr_i,
   output logic [31:0]                  head_data_o,
   output logic [WADDR_W-1:0]           head_addr_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [31:0]        data_q [DEPTH];
   logic [WADDR_W-1:0] addr_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               w_push;
   logic               w_pop;

   assign w_pop  = pop_i & (count_q != '0);
   assign w_push = push_i & ((count_q != CNT_W'(DEPTH)) | w_pop);

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (w_push && !w_pop)      count_q <= count_q + CNT_W'(1);
         else if (w_pop && !w_push) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage needs no reset: entries are only read once count covers them.
   always_ff @(posedge clk) begin
      if (w_push && !flush_i && !rst) begin
         data_q[wr_ptr_q] <= push_data_i;
         addr_q[wr_ptr_q] <= push_addr_i;
      end
   end

   assign head_data_o = data_q[rd_ptr_q];
   assign head_addr_o = addr_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/cm0_prefetch_unit.sv
// +--------------------------------------------------------------------+
// | cm0_prefetch_unit : Thumb word prefetch with halfword stream out   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cm0_prefetch_unit
   import cm0_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        mem_req,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_ack,
   input  logic [31:0]                 mem_rdata,
   output logic                        ins_valid,
   input  logic                        ins_ready,
   output logic [15:0]                 ins_data,
   output logic [ADDR_W-1:0]           ins_pc,
   input  logic                        br_taken,
   input  logic [ADDR_W-1:0]           br_target,
   output logic [$clog2(DEPTH+1)-1:0]  buf_count
);

   localparam int unsigned WA_W  = ADDR_W - 2;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fetch_state_e       state_q;
   logic               mem_req_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [ADDR_W-1:0]  fetch_addr_q;
   logic               hw_sel_q;
   logic               skip_lo_q;

   logic [31:0]        w_head_data;
   logic [WA_W-1:0]    w_head_addr;
   logic [CNT_W-1:0]   w_count;
   logic               w_valid;
   logic               w_consume;
   logic               w_push;
   logic               w_pop;
   logic               w_unused;

   assign w_valid   = (w_count != '0);
   assign w_consume = w_valid & ins_ready & ~br_taken;
   assign w_push    = (state_q == S_WAIT) & mem_ack & ~br_taken;
   assign w_pop     = w_consume & hw_sel_q;
   assign w_unused  = br_target[0];

   cm0_fetch_fifo #(
      .DEPTH   (DEPTH),
      .WADDR_W (WA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .pop_i       (w_pop),
      .flush_i     (br_taken),
      .push_data_i (mem_rdata),
      .push_addr_i (fetch_addr_q[ADDR_W-1:2]),
      .head_data_o (w_head_data),
      .head_addr_o (w_head_addr),
      .count_o     (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= {RESET_PC[ADDR_W-1:2], 2'b00};
         fetch_addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
         hw_sel_q     <= 1'b0;
         skip_lo_q    <= 1'b0;
      end else begin
         // Issue decision uses the registered count, so a same-cycle pop never frees a slot.
         case (state_q)
            S_IDLE: begin
               if (!br_taken && (w_count < CNT_W'(DEPTH))) begin
                  state_q    <= S_WAIT;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_addr_q;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
               end else if (br_taken) begin
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               if (mem_ack) begin
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase

         if (br_taken) begin
            fetch_addr_q <= {br_target[ADDR_W-1:2], 2'b00};
            skip_lo_q    <= br_target[1];
            hw_sel_q     <= 1'b0;
         end else begin
            if (w_push) begin
               fetch_addr_q <= fetch_addr_q + ADDR_W'(WORD_BYTES);
               if (skip_lo_q) begin
                  hw_sel_q  <= 1'b1;
                  skip_lo_q <= 1'b0;
               end
            end
            if (w_consume) hw_sel_q <= ~hw_sel_q;
         end
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign ins_valid = w_valid;
   assign ins_data  = hw_sel_q ? w_head_data[31:16] : w_head_data[15:0];
   assign ins_pc    = {w_head_addr, 2'b00} + (hw_sel_q ? ADDR_W'(HW_BYTES) : '0);
   assign buf_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_cm0_prefetch_unit.sv
// +--------------------------------------------------------------------+
// | tb_cm0_prefetch_unit : bench for cm0_prefetch_unit                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cm0_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        ins_valid;
   logic        ins_ready;
   logic [15:0] ins_data;
   logic [31:0] ins_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic [2:0]  buf_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cm0_prefetch_unit #(
      .ADDR_W   (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .ins_data  (ins_data),
      .ins_pc    (ins_pc),
      .br_taken  (br_taken),
      .br_target (br_target),
      .buf_count (buf_count)
   );

   // Memory image: each halfword is a fixed function of its byte address.
   function automatic logic [15:0] hw_at(input logic [31:0] a);
      return a[16:1] ^ a[31:16] ^ 16'h5A3C;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {hw_at(a + 32'd2), hw_at(a)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_ack = 1'b0; ins_ready = 1'b0; br_taken = 1'b0;
      br_target = '0; mem_rdata = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      chk(nm, {31'd0, mem_req}, 32'd1);
   endtask

   typedef struct {
      logic        ack;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   vec_t tbl [9];

   // Reference model state for the randomized run
   logic [31:0] m_pc, m_fetch, r_addr, tgt;
   int          m_cnt, prev_cnt, lat, nreq;
   logic        act, taint, prev_br, br, rdy, ack, consume, push, pop;

   initial begin
      // ack latency 1: ack lands in the first cycle mem_req is seen
      tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h102, 1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h106, 2};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h108, 1};
      tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h108, 1};

      // ---- sequential stream after reset ----
      do_reset();
      for (int i = 0; i < 9; i++) begin
         chk("t1_req", {31'd0, mem_req}, {31'd0, tbl[i].e_req});
         if (tbl[i].e_req) chk("t1_addr", mem_addr, tbl[i].e_addr);
         chk("t1_valid", {31'd0, ins_valid}, {31'd0, tbl[i].e_valid});
         chk("t1_cnt", {29'd0, buf_count}, tbl[i].e_cnt);
         if (tbl[i].e_valid) begin
            chk("t1_pc", ins_pc, tbl[i].e_pc);
            chk("t1_data", {16'd0, ins_data}, {16'd0, hw_at(tbl[i].e_pc)});
         end
         mem_ack   = tbl[i].ack;
         ins_ready = tbl[i].ready;
         mem_rdata = word_at(mem_addr);
         tick();
      end

      // ---- buffer fills with decode stalled ----
      do_reset();
      nreq = 0;
      for (int c = 0; c < 40; c++) begin
         mem_ack   = mem_req;
         mem_rdata = word_at(mem_addr);
         if (mem_req) nreq++;
         tick();
      end
      mem_ack = 1'b0;
      chk("t2_nreq", nreq, 4);
      chk("t2_cnt_full", {29'd0, buf_count}, 32'd4);
      chk("t2_req_idle", {31'd0, mem_req}, 32'd0);
      ins_ready = 1'b1; tick();
      tick();
      ins_ready = 1'b0;
      chk("t2_cnt_pop", {29'd0, buf_count}, 32'd3);
      chk("t2_no_same_cycle_issue", {31'd0, mem_req}, 32'd0);
      chk("t2_pc_after_pop", ins_pc, 32'h104);
      tick();
      chk("t2_resume_req", {31'd0, mem_req}, 32'd1);
      chk("t2_resume_addr", mem_addr, 32'h110);

      // ---- branch while waiting, ack three cycles later ----
      do_reset();
      wait_req("t3_first_req");
      br_taken = 1'b1; br_target = 32'h20A;
      tick();
      br_taken = 1'b0;
      chk("t3_drop_req", {31'd0, mem_req}, 32'd1);
      chk("t3_drop_addr", mem_addr, 32'h100);
      tick();
      mem_ack = 1'b1; mem_rdata = word_at(32'h100);
      tick();
      mem_ack = 1'b0;
      chk("t3_discard_cnt", {29'd0, buf_count}, 32'd0);
      chk("t3_discard_valid", {31'd0, ins_valid}, 32'd0);
      tick();
      chk("t3_target_req", {31'd0, mem_req}, 32'd1);
      chk("t3_target_addr", mem_addr, 32'h208);
      mem_ack = 1'b1; mem_rdata = word_at(32'h208);
      tick();
      mem_ack = 1'b0;
      chk("t3_first_pc", ins_pc, 32'h20A);
      chk("t3_first_data", {16'd0, ins_data}, {16'd0, hw_at(32'h20A)});
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
      chk("t3_after_pop_valid", {31'd0, ins_valid}, 32'd0);
      chk("t3_next_addr", mem_addr, 32'h20C);

      // ---- branch coinciding with ack and consume ----
      do_reset();
      wait_req("t4_first_req");
      mem_ack = 1'b1; mem_rdata = word_at(32'h100);
      tick();
      mem_ack = 1'b0;
      tick();
      chk("t4_second_addr", mem_addr, 32'h104);
      mem_ack = 1'b1; mem_rdata = word_at(32'h104);
      ins_ready = 1'b1; br_taken = 1'b1; br_target = 32'h300;
      tick();
      mem_ack = 1'b0; ins_ready = 1'b0; br_taken = 1'b0;
      chk("t4_flush_cnt", {29'd0, buf_count}, 32'd0);
      chk("t4_flush_valid", {31'd0, ins_valid}, 32'd0);
      chk("t4_no_req", {31'd0, mem_req}, 32'd0);
      tick();
      chk("t4_target_addr", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_rdata = word_at(32'h300);
      tick();
      mem_ack = 1'b0;
      chk("t4_first_pc", ins_pc, 32'h300);
      chk("t4_first_data", {16'd0, ins_data}, {16'd0, hw_at(32'h300)});

      // ---- reset while dropping, with pending and late acks ----
      do_reset();
      wait_req("t6_first_req");
      br_taken = 1'b1; br_target = 32'h400;
      tick();
      br_taken = 1'b0;
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = word_at(32'h100);
      tick();
      rst = 1'b0;
      chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
      chk("t6_rst_valid", {31'd0, ins_valid}, 32'd0);
      chk("t6_rst_cnt", {29'd0, buf_count}, 32'd0);
      tick();
      mem_ack = 1'b0;
      chk("t6_late_ack_cnt", {29'd0, buf_count}, 32'd0);
      chk("t6_refetch_addr", mem_addr, 32'h100);
      mem_ack = 1'b1; mem_rdata = word_at(32'h100);
      tick();
      mem_ack = 1'b0;
      chk("t6_first_pc", ins_pc, 32'h100);

      // ---- randomized run against the stream model; starts with a wrap ----
      do_reset();
      m_cnt = 0; m_pc = 32'h100; m_fetch = 32'h100;
      act = 1'b0; taint = 1'b0; lat = 0; r_addr = '0; prev_cnt = 0; prev_br = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_cnt", {29'd0, buf_count}, m_cnt);
         chk("rnd_valid", {31'd0, ins_valid}, {31'd0, m_cnt != 0});
         if (mem_req && !act) begin
            chk("rnd_fetch_addr", mem_addr, m_fetch);
            chk("rnd_issue_ok", {31'd0, (prev_cnt < 4) && !prev_br}, 32'd1);
            act = 1'b1; taint = 1'b0; r_addr = mem_addr; lat = $urandom_range(0, 3);
         end else if (act) begin
            chk("rnd_hold_req", {31'd0, mem_req}, 32'd1);
            chk("rnd_hold_addr", mem_addr, r_addr);
         end

         br  = (c == 0) || (c > 60 && $urandom_range(0, 19) == 0);
         tgt = (c == 0) ? 32'hFFFF_FFF6 : $urandom;
         rdy = ((c / 200) % 2 == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
         if (act) begin
            ack = (lat == 0);
            if (lat > 0) lat--;
         end else begin
            ack = ($urandom_range(0, 7) == 0);
         end
         consume = ins_valid && rdy;
         if (consume && !br) begin
            chk("rnd_pc", ins_pc, m_pc);
            chk("rnd_data", {16'd0, ins_data}, {16'd0, hw_at(m_pc)});
         end

         br_taken  = br;
         br_target = tgt;
         ins_ready = rdy;
         mem_ack   = ack;
         mem_rdata = (ack && act) ? word_at(r_addr) : $urandom;

         prev_cnt = m_cnt;
         prev_br  = br;
         if (br) begin
            m_cnt   = 0;
            m_pc    = tgt & 32'hFFFF_FFFE;
            m_fetch = tgt & 32'hFFFF_FFFC;
            if (act) taint = 1'b1;
         end else begin
            push = act && ack && !taint;
            pop  = consume && m_pc[1];
            if (consume) m_pc = m_pc + 32'd2;
            if (push) m_fetch = m_fetch + 32'd4;
            m_cnt = m_cnt + int'(push) - int'(pop);
         end
         if (act && ack) act = 1'b0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
